// File: rtl/mrd_sink_framer.sv
// Input framer for the mixed-radix DFT sink. It tags sop/eop on a raw sample stream,
// buffers it in a small FIFO behind a registered show-ahead output slot, and reports sticky status.
module mrd_sink_framer #(
    parameter int DW    = 18,
    parameter int PTSW  = 12,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic            in_start,
    input  logic [DW-1:0]   in_real,
    input  logic [DW-1:0]   in_imag,
    input  logic [PTSW-1:0] in_dftpts,
    input  logic            in_inverse,
    output logic            dft_valid,
    input  logic            dft_ready,
    output logic            dft_sop,
    output logic            dft_eop,
    output logic [DW-1:0]   dft_real,
    output logic [DW-1:0]   dft_imag,
    output logic [PTSW-1:0] dft_dftpts,
    output logic            dft_inverse,
    input  logic            clr_status,
    output logic            overflow,
    output logic            frame_err,
    output logic [AW:0]     fifo_level
);

    localparam int WW = 3 + PTSW + 2 * DW;
    localparam int P_IMAG = 0;
    localparam int P_REAL = DW;
    localparam int P_PTS  = 2 * DW;
    localparam int P_INV  = 2 * DW + PTSW;
    localparam int P_EOP  = P_INV + 1;
    localparam int P_SOP  = P_INV + 2;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    logic [PTSW-1:0] cnt;
    logic [PTSW-1:0] pts;
    logic            inv;
    logic            pts_ok;
    logic            err_evt;
    logic            last;

    // Tagged sample register: the framer captures here, the FIFO writes from here.
    logic            stg_vld;
    logic [WW-1:0]   stg_word;

    logic [WW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [AW:0]     level;
    logic            full;
    logic            empty;
    logic            wr;
    logic            rd;
    logic            drop;
    logic [WW-1:0]   rd_word;

    assign pts_ok = (in_dftpts >= PTSW'(2)) && (in_dftpts <= PTSW'(1200));
    assign last   = (cnt == pts - PTSW'(1));

    always_comb begin
        err_evt = 1'b0;
        if (in_valid) begin
            if (state == IDLE)
                err_evt = !(in_start && pts_ok);
            else
                err_evt = in_start;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            pts      <= '0;
            inv      <= 1'b0;
            stg_vld  <= 1'b0;
            stg_word <= '0;
        end else begin
            stg_vld <= 1'b0;
            if (in_valid) begin
                case (state)
                    IDLE: begin
                        if (in_start && pts_ok) begin
                            pts      <= in_dftpts;
                            inv      <= in_inverse;
                            stg_vld  <= 1'b1;
                            stg_word <= {1'b1, 1'b0, in_inverse, in_dftpts, in_real, in_imag};
                            cnt      <= PTSW'(1);
                            state    <= RUN;
                        end
                    end
                    RUN: begin
                        // A stray in_start here is plain data; the frame keeps its latched length.
                        stg_vld  <= 1'b1;
                        stg_word <= {1'b0, last, inv, pts, in_real, in_imag};
                        if (last) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + PTSW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign full    = (level == (AW + 1)'(DEPTH));
    assign empty   = (level == '0);
    assign wr      = stg_vld && !full;
    assign drop    = stg_vld && full;
    assign rd      = !empty && (!dft_valid || dft_ready);
    assign rd_word = mem[rptr];

    always_ff @(posedge clk) begin
        if (wr)
            mem[wptr] <= stg_word;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (wr)
                wptr <= wptr + AW'(1);
            if (rd)
                rptr <= rptr + AW'(1);
            case ({wr, rd})
                2'b10:   level <= level + (AW + 1)'(1);
                2'b01:   level <= level - (AW + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    assign fifo_level = level;

    // Output slot: data fields only change on a load, so they hold while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dft_valid   <= 1'b0;
            dft_sop     <= 1'b0;
            dft_eop     <= 1'b0;
            dft_real    <= '0;
            dft_imag    <= '0;
            dft_dftpts  <= '0;
            dft_inverse <= 1'b0;
        end else if (rd) begin
            dft_valid   <= 1'b1;
            dft_sop     <= rd_word[P_SOP];
            dft_eop     <= rd_word[P_EOP];
            dft_inverse <= rd_word[P_INV];
            dft_dftpts  <= rd_word[P_PTS +: PTSW];
            dft_real    <= rd_word[P_REAL +: DW];
            dft_imag    <= rd_word[P_IMAG +: DW];
        end else if (dft_valid && dft_ready) begin
            dft_valid <= 1'b0;
        end
    end

    // Sticky status: a new event beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (drop)
                overflow <= 1'b1;
            else if (clr_status)
                overflow <= 1'b0;
            if (err_evt)
                frame_err <= 1'b1;
            else if (clr_status)
                frame_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mrd_sink_framer.sv
// Directed bench for mrd_sink_framer: expected beats are queued as samples are driven
// and compared in order against beats captured at the DFT handshake.
module tb_mrd_sink_framer;

    localparam int DW    = 18;
    localparam int PTSW  = 12;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);
    localparam int BW    = 3 + PTSW + 2 * DW;

    typedef logic [BW-1:0] beat_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid, in_start, in_inverse;
    logic [DW-1:0]   in_real, in_imag;
    logic [PTSW-1:0] in_dftpts;
    logic            dft_valid, dft_ready, dft_sop, dft_eop, dft_inverse;
    logic [DW-1:0]   dft_real, dft_imag;
    logic [PTSW-1:0] dft_dftpts;
    logic            clr_status, overflow, frame_err;
    logic [AW:0]     fifo_level;

    mrd_sink_framer #(.DW(DW), .PTSW(PTSW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_start(in_start), .in_real(in_real), .in_imag(in_imag),
        .in_dftpts(in_dftpts), .in_inverse(in_inverse),
        .dft_valid(dft_valid), .dft_ready(dft_ready), .dft_sop(dft_sop), .dft_eop(dft_eop),
        .dft_real(dft_real), .dft_imag(dft_imag), .dft_dftpts(dft_dftpts),
        .dft_inverse(dft_inverse), .clr_status(clr_status), .overflow(overflow),
        .frame_err(frame_err), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int    cyc = 0;
    always @(posedge clk) cyc++;

    beat_t cur;
    assign cur = {dft_sop, dft_eop, dft_inverse, dft_dftpts, dft_real, dft_imag};

    // Monitor: only records; every comparison is made in the main sequence.
    beat_t obs_q[$];
    int    obs_cyc[$];
    int    stall_bad = 0;
    int    max_level = 0;
    bit    prev_stall = 1'b0;
    beat_t prev_out;

    always @(negedge clk) begin
        if (rst_n && dft_valid && dft_ready) begin
            obs_q.push_back(cur);
            obs_cyc.push_back(cyc);
        end
        if (rst_n && prev_stall && cur !== prev_out)
            stall_bad++;
        prev_stall = rst_n && dft_valid && !dft_ready;
        prev_out   = cur;
        if (int'(fifo_level) > max_level)
            max_level = int'(fifo_level);
    end

    int    n_chk = 0;
    int    n_fail = 0;
    beat_t exp_q[$];
    int    rd_idx = 0;
    int    start_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic put(input bit st, input int pts, input bit inv,
                       input logic [DW-1:0] re, input logic [DW-1:0] im);
        in_valid   = 1'b1;
        in_start   = st;
        in_dftpts  = PTSW'(pts);
        in_inverse = inv;
        in_real    = re;
        in_imag    = im;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_start = 1'b0;
    endtask

    // Sends n samples of a frame declared as pts; the first keep samples are expected out.
    // Sample 'bad' carries a stray in_start with a different length and inverse bit.
    task automatic frame(input int pts, input int n, input bit inv, input int fid,
                         input int keep, input bit tog, input int bad = -1);
        logic [DW-1:0] re, im;
        for (int i = 0; i < n; i++) begin
            re = DW'(fid * 64 + i);
            im = ~re;
            if (i < keep)
                exp_q.push_back({(i == 0), (i == pts - 1), inv, PTSW'(pts), re, im});
            if (i == bad)
                put(1'b1, 5, ~inv, re, im);
            else
                put(i == 0, pts, inv, re, im);
            if (i == 0)
                start_cyc = cyc;
            if (tog)
                dft_ready = ~dft_ready;
        end
    endtask

    task automatic drain(input string tag, input bit tog);
        int idle = 0;
        int budget = 400;
        int got;
        while (idle < 3 && budget > 0) begin
            @(posedge clk); #1;
            if (tog)
                dft_ready = ~dft_ready;
            if (!dft_valid && fifo_level == '0)
                idle++;
            else
                idle = 0;
            budget--;
        end
        chk({tag, "_timeout"}, 64'(budget == 0), 64'(0));
        got = obs_q.size() - rd_idx;
        chk({tag, "_count"}, 64'(got), 64'(exp_q.size()));
        for (int i = 0; i < got && i < exp_q.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), 64'(obs_q[rd_idx + i]), 64'(exp_q[i]));
        rd_idx = obs_q.size();
        exp_q.delete();
    endtask

    task automatic pulse_clr();
        clr_status = 1'b1;
        @(posedge clk); #1;
        clr_status = 1'b0;
    endtask

    initial begin
        int base;
        rst_n = 1'b0; in_valid = 1'b0; in_start = 1'b0; in_inverse = 1'b0;
        in_real = '0; in_imag = '0; in_dftpts = '0; dft_ready = 1'b1; clr_status = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({dft_valid, cur, overflow, frame_err, fifo_level}), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single 12-point inverse frame, ready held high.
        base = obs_q.size();
        frame(12, 12, 1'b1, 1, 12, 1'b0);
        drain("single", 1'b0);
        if (obs_cyc.size() > base)
            chk("single_latency", 64'(obs_cyc[base] - start_cyc), 64'(2));
        else
            chk("single_latency_missing", 64'(obs_cyc.size()), 64'(base + 1));

        // Backpressure: ready toggles every cycle.
        dft_ready = 1'b0;
        frame(24, 24, 1'b0, 2, 24, 1'b1);
        drain("bp", 1'b1);
        dft_ready = 1'b1;
        chk("bp_stall_stable", 64'(stall_bad), 64'(0));
        chk("bp_no_overflow", 64'(overflow), 64'(0));
        chk("bp_level_bound", 64'(max_level <= DEPTH), 64'(1));

        // Overflow: 16 in FIFO + 1 in the slot, 3 dropped, eop lost.
        dft_ready = 1'b0;
        frame(20, 20, 1'b0, 3, 17, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_level_full", 64'(fifo_level), 64'(DEPTH));
        chk("ovf_flag", 64'(overflow), 64'(1));
        chk("ovf_slot_valid", 64'(dft_valid), 64'(1));
        dft_ready = 1'b1;
        drain("ovf", 1'b0);
        frame(12, 12, 1'b0, 4, 12, 1'b0);
        drain("after_ovf", 1'b0);

        // clr_status clears, but loses to a coincident overflow.
        pulse_clr();
        chk("clr_overflow", 64'(overflow), 64'(0));
        dft_ready = 1'b0;
        clr_status = 1'b1;
        frame(20, 20, 1'b1, 5, 17, 1'b0);
        @(posedge clk); #1;
        clr_status = 1'b0;
        chk("clr_vs_set", 64'(overflow), 64'(1));
        dft_ready = 1'b1;
        drain("ovf2", 1'b0);
        pulse_clr();
        chk("clr_both", 64'({overflow, frame_err}), 64'(0));

        // Framing errors.
        put(1'b0, 12, 1'b0, DW'(7), DW'(9));
        chk("err_idle_data", 64'(frame_err), 64'(1));
        drain("err_idle", 1'b0);
        pulse_clr();
        put(1'b1, 0, 1'b0, DW'(1), DW'(2));
        put(1'b0, 0, 1'b0, DW'(3), DW'(4));
        chk("err_pts0", 64'(frame_err), 64'(1));
        drain("err_pts0", 1'b0);
        pulse_clr();
        put(1'b1, 1201, 1'b1, DW'(5), DW'(6));
        put(1'b0, 1201, 1'b1, DW'(7), DW'(8));
        chk("err_pts1201", 64'(frame_err), 64'(1));
        drain("err_pts1201", 1'b0);
        pulse_clr();
        frame(2, 2, 1'b1, 6, 2, 1'b0);
        drain("pts2", 1'b0);
        chk("pts2_no_err", 64'(frame_err), 64'(0));
        frame(8, 8, 1'b1, 7, 8, 1'b0, 3);
        chk("err_midstart", 64'(frame_err), 64'(1));
        drain("midstart", 1'b0);
        pulse_clr();

        // Reset mid-frame discards everything.
        dft_ready = 1'b0;
        frame(12, 6, 1'b0, 8, 0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_mid_outputs", 64'({dft_valid, cur, overflow, frame_err, fifo_level}), 64'(0));
        dft_ready = 1'b1;
        drain("rst_mid", 1'b0);
        frame(12, 12, 1'b0, 9, 12, 1'b0);
        drain("after_rst", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mrd_sink_framer.md
Name: mrd_sink_framer

Overview:
- Input framing stage that sits directly upstream of the mixed-radix DFT top. It drives that block's sink interface: sink_valid/ready, sop, eop, real, imag, dftpts and inverse.
- It accepts a raw sample stream with a frame-start strobe and a per-frame point count. It tags the first and last sample of each frame with sop/eop.
- A small FIFO absorbs sink_ready backpressure. Overflow and framing errors are reported as status.

Parameters:
DW, 18, sample width of real and imag parts
PTSW, 12, dftpts width
DEPTH, 16, FIFO entries (power of 2, >=4); AW = log2(DEPTH)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  sample present this cycle (no backpressure on input side)
in_start  in  1  first sample of a frame; qualified by in_valid
in_real  in  DW  sample real part
in_imag  in  DW  sample imag part
in_dftpts  in  PTSW  frame length, sampled with in_start
in_inverse  in  1  IDFT select, sampled with in_start
dft_valid  out  1  to DFT sink_valid
dft_ready  in  1  from DFT sink_ready
dft_sop  out  1  to DFT sink_sop
dft_eop  out  1  to DFT sink_eop
dft_real  out  DW  to DFT sink_real
dft_imag  out  DW  to DFT sink_imag
dft_dftpts  out  PTSW  to DFT dftpts_in; constant across a frame
dft_inverse  out  1  to DFT inverse; constant across a frame
clr_status  in  1  clears sticky status bits
overflow  out  1  sticky: sample dropped because FIFO was full
frame_err  out  1  sticky: framing violation
fifo_level  out  AW+1  FIFO occupancy, excluding the output register

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FSM goes to IDLE; counter=0; FIFO emptied.
  - dft_valid, dft_sop, dft_eop, dft_real, dft_imag, dft_dftpts, dft_inverse, overflow, frame_err and fifo_level all =0.
  - Reset mid-frame discards the partial frame and the FIFO contents. No eop is emitted.
- Framing FSM, states IDLE and RUN:
  - IDLE, in_valid & in_start & 2<=in_dftpts<=1200:
    - latch pts=in_dftpts and inv=in_inverse;
    - write sample tagged sop=1;
    - counter=1; go to RUN.
  - IDLE, in_valid & in_start with in_dftpts outside 2..1200: sample dropped, frame_err set, stay IDLE. The following samples are dropped until the next start.
  - IDLE, in_valid & !in_start: sample dropped, frame_err set.
  - RUN, in_valid: write sample with sop=0 and eop=(counter==pts-1); counter+=1.
    - After the eop sample: go to IDLE, counter=0.
  - RUN, in_valid & in_start: in_start is ignored. The sample is treated as ordinary data and frame_err is set. The frame continues to its declared length.
  - in_valid=0: no state change.
- Each FIFO word holds {sop, eop, inv, pts, real, imag}, captured at the write cycle.
- Full handling:
  - full = (fifo_level==DEPTH), evaluated before this cycle's read.
  - A write when full is dropped and overflow is set. The framing counter still advances, so sop/eop alignment of later frames is preserved.
  - A read in the same cycle does not rescue the write.
- Output stage:
  - One registered output slot fed from the FIFO, with show-ahead behaviour.
  - The slot loads when it is empty or (dft_valid & dft_ready), provided the FIFO is non-empty.
  - While dft_valid=1 & dft_ready=0, all dft_* outputs hold stable.
  - dft_valid drops to 0 when the slot is consumed and the FIFO is empty.
- Latency: a sample written at edge N, with the FIFO and slot empty, appears on dft_* after edge N+2.
- Throughput: 1 sample/cycle with dft_ready held high.
- fifo_level updates every cycle: +1 on write, -1 on read, net 0 when both occur.
- Sticky bits: set on the cycle after the event and held until clr_status=1. If clr_status and a new event occur in the same cycle, the bit stays set (set wins).
- dftpts range check is unsigned. The PTSW width is only declared; values above 1200 are treated as errors.

Test Plan:
- Single frame, in_dftpts=12, inverse=1, dft_ready=1 -> 12 dft_valid beats; sop on beat 0, eop on beat 11; dft_dftpts=12 and dft_inverse=1 on all beats; first beat 2 cycles after in_start.
- Backpressure: 24-point frame, dft_ready toggling 1/0 every cycle -> output values held while stalled; all 24 samples delivered in order; no overflow; fifo_level peaks <=DEPTH.
- Overflow: DEPTH=16, dft_ready=0, 20-point frame -> 17 samples stored (16 FIFO + 1 output slot); 3 dropped; overflow=1; eop still lands on the 20th input sample's position, so no eop is delivered. A following 12-point frame then delivers a correct sop..eop.
- Framing errors, each -> frame_err=1 with no extra output beats:
  - in_valid without in_start while IDLE;
  - in_start with in_dftpts=0 or 1201;
  - in_start mid-frame -> that sample is delivered as data and the frame still ends at its declared length.
- clr_status: after overflow=1, pulse clr_status -> overflow=0 next cycle. A clr_status coincident with a new overflow event -> overflow stays 1.
- Reset mid-frame: 6 of 12 samples in, rst_n=0 for 1 cycle -> all outputs 0 and fifo_level=0. A new 12-point frame afterwards delivers exactly 12 beats with correct sop/eop.
